// File: rtl/xadc_sensor_monitor.sv
// XADC readback monitor: boxcar averages for temp/VCCINT/VCCAUX, over-temp hysteresis, 4-phase read port.
// Optional per-channel min/max of averages when MON_MINMAX_EN is defined (addr 5..A).
module xadc_sensor_monitor #(
    parameter int          AVG_LOG2 = 4,
    parameter logic [11:0] TEMP_HI  = 12'hB5F,
    parameter logic [11:0] TEMP_LO  = 12'hB0E
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] adc_data_in,
    input  logic [4:0]  adc_channel_in,
    input  logic        adc_drdy_in,
    input  logic        adc_eos_in,
    input  logic        adc_alarm_in,
    input  logic        rd_req_in,
    input  logic [3:0]  rd_addr_in,
    output logic [15:0] rd_data_out,
    output logic        rd_ack_out,
    output logic        over_temp_out
);

    localparam int AW = 12 + AVG_LOG2;

    typedef enum logic {RD_IDLE, RD_ACK} rd_state_t;

    logic [11:0]         code;
    logic                unused_nibble;
    logic [AW-1:0]       acc_q [3];
    logic [AW-1:0]       acc_d [3];
    logic [AW-1:0]       sum   [3];
    logic [AVG_LOG2-1:0] cnt_q [3];
    logic [AVG_LOG2-1:0] cnt_d [3];
    logic [11:0]         avg_q [3];
    logic [11:0]         avg_d [3];
    logic [2:0]          valid_q, valid_d, avg_upd;
    logic                over_temp_q, over_temp_d;
    logic                sticky_q, sticky_d;
    logic [15:0]         seq_q, seq_d;
    logic [15:0]         rd_data_q, rd_data_d, rd_mux;
    logic [3:0]          addr_q, addr_d;
    rd_state_t           state_q, state_d;
    logic                rd_load, rd_done, stat_clr;

    assign code          = adc_data_in[15:4];
    assign unused_nibble = ^adc_data_in[3:0];

    // The final sample of a window goes straight into the average, never into acc.
    always_comb begin
        valid_d = valid_q;
        avg_upd = '0;
        for (int ch = 0; ch < 3; ch++) begin
            acc_d[ch] = acc_q[ch];
            cnt_d[ch] = cnt_q[ch];
            avg_d[ch] = avg_q[ch];
            sum[ch]   = acc_q[ch] + AW'(code);
            if (adc_drdy_in && adc_channel_in == 5'(ch)) begin
                cnt_d[ch] = cnt_q[ch] + AVG_LOG2'(1);
                if (cnt_q[ch] == '1) begin
                    avg_d[ch]   = sum[ch][AW-1:AVG_LOG2];
                    acc_d[ch]   = '0;
                    valid_d[ch] = 1'b1;
                    avg_upd[ch] = 1'b1;
                end else begin
                    acc_d[ch] = sum[ch];
                end
            end
        end
    end

    always_comb begin
        over_temp_d = over_temp_q;
        if (avg_upd[0]) begin
            if (avg_d[0] >= TEMP_HI)     over_temp_d = 1'b1;
            else if (avg_d[0] < TEMP_LO) over_temp_d = 1'b0;
        end
        seq_d    = adc_eos_in ? seq_q + 16'd1 : seq_q;
        sticky_d = adc_alarm_in ? 1'b1 : (stat_clr ? 1'b0 : sticky_q);
    end

`ifdef MON_MINMAX_EN
    logic [11:0] min_q [3];
    logic [11:0] min_d [3];
    logic [11:0] max_q [3];
    logic [11:0] max_d [3];

    // A clear coinciding with an average update restarts tracking from that average.
    always_comb begin
        for (int ch = 0; ch < 3; ch++) begin
            min_d[ch] = stat_clr ? 12'hFFF : min_q[ch];
            max_d[ch] = stat_clr ? 12'h000 : max_q[ch];
            if (avg_upd[ch]) begin
                if (avg_d[ch] < min_d[ch]) min_d[ch] = avg_d[ch];
                if (avg_d[ch] > max_d[ch]) max_d[ch] = avg_d[ch];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int ch = 0; ch < 3; ch++) begin
                min_q[ch] <= 12'hFFF;
                max_q[ch] <= 12'h000;
            end
        end else begin
            for (int ch = 0; ch < 3; ch++) begin
                min_q[ch] <= min_d[ch];
                max_q[ch] <= max_d[ch];
            end
        end
    end
`endif

    always_comb begin
        rd_mux = 16'h0000;
        case (rd_addr_in)
            4'h0: rd_mux = {4'h0, avg_q[0]};
            4'h1: rd_mux = {4'h0, avg_q[1]};
            4'h2: rd_mux = {4'h0, avg_q[2]};
            4'h3: rd_mux = {10'h0, sticky_q, over_temp_q, valid_q, adc_alarm_in};
            4'h4: rd_mux = seq_q;
`ifdef MON_MINMAX_EN
            4'h5: rd_mux = {4'h0, min_q[0]};
            4'h6: rd_mux = {4'h0, max_q[0]};
            4'h7: rd_mux = {4'h0, min_q[1]};
            4'h8: rd_mux = {4'h0, max_q[1]};
            4'h9: rd_mux = {4'h0, min_q[2]};
            4'hA: rd_mux = {4'h0, max_q[2]};
`endif
            default: rd_mux = 16'h0000;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RD_IDLE: if (rd_req_in)  state_d = RD_ACK;
            RD_ACK:  if (!rd_req_in) state_d = RD_IDLE;
            default: state_d = RD_IDLE;
        endcase
    end

    // Read data is loaded from the pre-update registers and frozen for the whole ACK phase.
    always_comb begin
        rd_ack_out = (state_q == RD_ACK);
        rd_load    = (state_q == RD_IDLE) && rd_req_in;
        rd_done    = (state_q == RD_ACK) && !rd_req_in;
        stat_clr   = rd_done && (addr_q == 4'h3);
        rd_data_d  = rd_load ? rd_mux : rd_data_q;
        addr_d     = rd_load ? rd_addr_in : addr_q;
    end

    assign rd_data_out   = rd_data_q;
    assign over_temp_out = over_temp_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int ch = 0; ch < 3; ch++) begin
                acc_q[ch] <= '0;
                cnt_q[ch] <= '0;
                avg_q[ch] <= '0;
            end
            valid_q     <= '0;
            over_temp_q <= 1'b0;
            sticky_q    <= 1'b0;
            seq_q       <= '0;
            rd_data_q   <= '0;
            addr_q      <= '0;
            state_q     <= RD_IDLE;
        end else begin
            for (int ch = 0; ch < 3; ch++) begin
                acc_q[ch] <= acc_d[ch];
                cnt_q[ch] <= cnt_d[ch];
                avg_q[ch] <= avg_d[ch];
            end
            valid_q     <= valid_d;
            over_temp_q <= over_temp_d;
            sticky_q    <= sticky_d;
            seq_q       <= seq_d;
            rd_data_q   <= rd_data_d;
            addr_q      <= addr_d;
            state_q     <= state_d;
        end
    end

endmodule
